jpeg_block_sequencer: RTL and testbench

JPEG_BLOCK_SEQUENCER -- requirements
Module: jpeg_block_sequencer

---
 rtl/jpeg_block_sequencer.sv | 131 +++++++++++++
 tb/tb_jpeg_block_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/jpeg_block_sequencer.sv
// Row sequencer for a DCT/IDCT datapath: streams input row reads, then output row
// writes PIPE_LAT cycles later. Define JPEG_SEQ_PERF_EN to add the frame_cycles counter.
module jpeg_block_sequencer #(
  parameter int ADDR_W   = 15,
  parameter int PIPE_LAT = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_rows,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              pipe_rst_n,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              blk_start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
`ifdef JPEG_SEQ_PERF_EN
  ,
  output logic [31:0]       frame_cycles
`endif
);

  // state | meaning
  // IDLE  | waiting for start, datapath held in reset
  // RUN   | reading rows (cyc < L) and writing rows (PIPE_LAT <= cyc < PIPE_LAT+L)
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     LAT_C = CW'(PIPE_LAT);
  localparam logic [ADDR_W-1:0] LAT_A = ADDR_W'(PIPE_LAT);

  state_t            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [CW-1:0]     last_cyc;
  logic              len_ok;
  logic              err_d, busy_d, done_d, pipe_d, rd_en_d, blk_d, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;

  assign len_ok   = (num_rows != '0) && (num_rows[2:0] == 3'b000);
  assign last_cyc = {1'b0, len_q} + LAT_C - CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    len_d   = len_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = RUN;
            cyc_d   = '0;
            len_d   = num_rows;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == last_cyc) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next-state values and registered, so they line up
  // with the state they describe without any combinational path from start/num_rows.
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    pipe_d    = (state_d == RUN);
    rd_en_d   = pipe_d && (cyc_d < {1'b0, len_d});
    rd_addr_d = rd_en_d ? cyc_d[ADDR_W-1:0] : '0;
    blk_d     = rd_en_d && (cyc_d[2:0] == 3'b000);
    wr_en_d   = pipe_d && (cyc_d >= LAT_C) && (cyc_d < ({1'b0, len_d} + LAT_C));
    wr_addr_d = wr_en_d ? (cyc_d[ADDR_W-1:0] - LAT_A) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pipe_rst_n <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      blk_start  <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      pipe_rst_n <= pipe_d;
      rd_en      <= rd_en_d;
      rd_addr    <= rd_addr_d;
      blk_start  <= blk_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
    end
  end

`ifdef JPEG_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)                                frame_cycles <= '0;
    else if (state_q == IDLE && start && len_ok) frame_cycles <= '0;
    else if (state_q == RUN)                  frame_cycles <= frame_cycles + 32'd1;
  end
`else
`endif

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Bench for jpeg_block_sequencer: directed vector table, hand-written corner sequences
// and random traffic, all checked every cycle against a frame-timeline reference model.
module tb_jpeg_block_sequencer;
  localparam int AW  = 15;
  localparam int LAT = 40;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] num_rows;
  logic          busy, done, err, pipe_rst_n, rd_en, blk_start, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
`ifdef JPEG_SEQ_PERF_EN
  logic [31:0]   frame_cycles;
`endif

  jpeg_block_sequencer #(.ADDR_W(AW), .PIPE_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done), .err(err), .pipe_rst_n(pipe_rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .blk_start(blk_start),
    .wr_en(wr_en), .wr_addr(wr_addr)
`ifdef JPEG_SEQ_PERF_EN
    , .frame_cycles(frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  // Model: a frame is the timeline that starts at the accepting edge m_t0;
  // sample k after it is RUN cycle k, k == LAT+len is the DONE cycle.
  int cyc_n = 0, m_t0 = 0, m_len = 0, m_err_at = -1;
  bit m_act = 1'b0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
    end
  endfunction

  task automatic model_edge(input bit s, input int r, input bit rs);
    int pk;
    bit prev_busy;
    pk = cyc_n - 1 - m_t0;
    prev_busy = m_act && (pk <= LAT + m_len);
    if (rs) begin
      m_act = 1'b0;
      m_err_at = -1;
    end else if (!prev_busy && s) begin
      if (r == 0 || (r % 8) != 0) m_err_at = cyc_n;
      else begin
        m_act = 1'b1;
        m_t0  = cyc_n;
        m_len = r;
      end
    end
  endtask

  task automatic check_outputs();
    int k, tot;
    bit bz, inrun, rd, wr;
    k     = cyc_n - m_t0;
    tot   = LAT + m_len;
    bz    = m_act && (k <= tot);
    inrun = m_act && (k < tot);
    rd    = inrun && (k < m_len);
    wr    = inrun && (k >= LAT);
    chk("busy",       int'(busy),       int'(bz));
    chk("done",       int'(done),       int'(m_act && k == tot));
    chk("err",        int'(err),        int'(cyc_n == m_err_at));
    chk("pipe_rst_n", int'(pipe_rst_n), int'(inrun));
    chk("rd_en",      int'(rd_en),      int'(rd));
    chk("rd_addr",    int'(rd_addr),    rd ? k : 0);
    chk("blk_start",  int'(blk_start),  int'(rd && (k % 8) == 0));
    chk("wr_en",      int'(wr_en),      int'(wr));
    chk("wr_addr",    int'(wr_addr),    wr ? k - LAT : 0);
`ifdef JPEG_SEQ_PERF_EN
    chk("frame_cycles", int'(frame_cycles), m_act ? ((k < tot) ? k : tot) : 0);
`endif
  endtask

  task automatic step(input bit s, input int r, input bit rs);
    start    = s;
    num_rows = AW'(r);
    reset    = rs;
    @(posedge clk);
    cyc_n++;
    model_edge(s, r, rs);
    @(negedge clk);
    check_outputs();
  endtask

  // Steps n cycles counting outputs from the current sample; at index inj_i the
  // given start/reset is injected into the following edge.
  task automatic observe(input int n, input int inj_i, input bit inj_s, input int inj_r,
                         input bit inj_rs, output int nrd, output int nwr, output int nblk,
                         output int didx, output int ndone, output int nerr, output int nbusy);
    nrd = 0; nwr = 0; nblk = 0; didx = -1; ndone = 0; nerr = 0; nbusy = 0;
    for (int i = 0; i < n; i++) begin
      nrd   += int'(rd_en);
      nwr   += int'(wr_en);
      nblk  += int'(blk_start);
      nerr  += int'(err);
      nbusy += int'(busy);
      if (done) begin
        ndone++;
        if (didx < 0) didx = i;
      end
      step(i == inj_i ? inj_s : 1'b0, inj_r, i == inj_i ? inj_rs : 1'b0);
    end
  endtask

  typedef struct {
    int rows;
    bit exp_err;
    int exp_rd;
    int exp_wr;
    int exp_blk;
    int exp_done;
  } vec_t;

  vec_t vt[6];
  int   nrd, nwr, nblk, didx, ndone, nerr, nbusy;
  int   pick[9];

  initial begin
    vt[0] = '{8,  1'b0, 8,  8,  1, 48};
    vt[1] = '{64, 1'b0, 64, 64, 8, 104};
    vt[2] = '{12, 1'b1, 0,  0,  0, -1};
    vt[3] = '{0,  1'b1, 0,  0,  0, -1};
    vt[4] = '{16, 1'b0, 16, 16, 2, 56};
    vt[5] = '{24, 1'b0, 24, 24, 3, 64};
    pick  = '{8, 16, 0, 12, 24, 40, 48, 56, 5};

    start = 1'b0; reset = 1'b1; num_rows = '0;
    @(negedge clk);
    step(1'b0, 0, 1'b1);
    step(1'b1, 8, 1'b1);
    chk("reset busy", int'(busy), 0);
    chk("reset pipe_rst_n", int'(pipe_rst_n), 0);
    step(1'b0, 0, 1'b0);

    foreach (vt[v]) begin
      step(1'b1, vt[v].rows, 1'b0);
      observe(vt[v].exp_err ? 4 : LAT + vt[v].rows + 3, -1, 1'b0, 0, 1'b0,
              nrd, nwr, nblk, didx, ndone, nerr, nbusy);
      chk($sformatf("vec%0d rd count", v),  nrd,   vt[v].exp_rd);
      chk($sformatf("vec%0d wr count", v),  nwr,   vt[v].exp_wr);
      chk($sformatf("vec%0d blk count", v), nblk,  vt[v].exp_blk);
      chk($sformatf("vec%0d done idx", v),  didx,  vt[v].exp_done);
      chk($sformatf("vec%0d err count", v), nerr,  int'(vt[v].exp_err));
      if (vt[v].exp_err) chk($sformatf("vec%0d busy count", v), nbusy, 0);
`ifdef JPEG_SEQ_PERF_EN
      if (vt[v].rows == 64) chk("frame_cycles held", int'(frame_cycles), 104);
`endif
    end

    // start mid-frame is ignored and does not relatch the length
    step(1'b1, 8, 1'b0);
    observe(60, 20, 1'b1, 16, 1'b0, nrd, nwr, nblk, didx, ndone, nerr, nbusy);
    chk("midstart done idx", didx, 48);
    chk("midstart done count", ndone, 1);
    chk("midstart rd count", nrd, 8);
    chk("midstart err count", nerr, 0);

    // reset at RUN cycle 20 aborts without done; next frame runs normally
    step(1'b1, 8, 1'b0);
    observe(70, 20, 1'b0, 0, 1'b1, nrd, nwr, nblk, didx, ndone, nerr, nbusy);
    chk("abort done count", ndone, 0);
    chk("abort busy count", nbusy, 21);
    step(1'b1, 8, 1'b0);
    observe(52, -1, 1'b0, 0, 1'b0, nrd, nwr, nblk, didx, ndone, nerr, nbusy);
    chk("after abort done idx", didx, 48);

    // start during the DONE cycle is ignored, then accepted from IDLE
    step(1'b1, 8, 1'b0);
    observe(48, -1, 1'b0, 0, 1'b0, nrd, nwr, nblk, didx, ndone, nerr, nbusy);
    chk("done cycle pulse", int'(done), 1);
    step(1'b1, 8, 1'b0);
    chk("start on done ignored", int'(busy), 0);
    step(1'b1, 8, 1'b0);
    chk("start in idle accepted", int'(busy), 1);
    observe(52, -1, 1'b0, 0, 1'b0, nrd, nwr, nblk, didx, ndone, nerr, nbusy);
    chk("restart done idx", didx, 48);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) == 0, pick[$urandom_range(0, 8)],
           $urandom_range(0, 149) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
